// File: rtl/pattern_scan_arb.sv
// pattern_scan_arb: two-requester round-robin arbiter feeding a serial
// overlapping "101" detector. The granted word is shifted out MSB first.
// Each detection sets the matching bit of match_mask and bumps a saturating count.
module pattern_scan_arb #(
   parameter int DW = 8
) (
   input  logic          Clk,
   input  logic          Clr,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] data0,
   input  logic [DW-1:0] data1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          busy,
   output logic          result_valid,
   output logic          result_id,
   output logic [3:0]    result_count,
   output logic [DW-1:0] match_mask
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } det_t;

   state_t        state_reg, state_next;
   det_t          det_reg, det_next;
   logic [DW-1:0] shift_reg;
   logic [DW-1:0] pos_reg;     // one-hot: mask position of the bit being consumed
   logic [DW-1:0] mask_reg, mask_next;
   logic [3:0]    count_reg, count_next;
   logic          id_reg;
   // Stored as "requester 0 served last" so that every register resets to
   // zero; a zero here means requester 1 was served last, so req0 wins the first tie.
   logic          last0_reg;
   logic          gnt0_reg, gnt1_reg;

   logic          grant;
   logic          win1;
   logic          serial_bit;
   logic          last_bit;
   logic          hit;

   assign grant      = (state_reg == IDLE) && (req0 || req1);
   assign win1       = req1 && (!req0 || last0_reg);
   assign serial_bit = shift_reg[DW-1];
   assign last_bit   = pos_reg[0];
   assign hit        = (det_reg == S2) && serial_bit;

   // State register with asynchronous clear.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic. An unused encoding falls back to IDLE.
   always_comb begin
      state_next = IDLE;
      case (state_reg)
         IDLE:    state_next = grant ? SHIFT : IDLE;
         SHIFT:   state_next = last_bit ? REPORT : SHIFT;
         REPORT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are decoded from the registered state.
   always_comb begin
      busy         = (state_reg != IDLE);
      result_valid = (state_reg == REPORT);
   end

   // Overlapping "101" detector transition for the current serial bit.
   always_comb begin
      det_next = S0;
      case (det_reg)
         S0:      det_next = serial_bit ? S1 : S0;
         S1:      det_next = serial_bit ? S1 : S2;
         S2:      det_next = serial_bit ? S3 : S0;
         S3:      det_next = serial_bit ? S1 : S2;
         default: det_next = S0;
      endcase
   end

   // A detection marks the mask bit that the one-hot position currently points at.
   generate
      for (genvar gi = 0; gi < DW; gi++) begin : g_mask
         assign mask_next[gi] = mask_reg[gi] | (hit & pos_reg[gi]);
      end
   endgenerate

   assign count_next = (hit && (count_reg != 4'd15)) ? count_reg + 4'd1 : count_reg;

   // Datapath: the grant loads a job, SHIFT consumes one bit per edge, and
   // results hold untouched from REPORT until the next grant.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         gnt0_reg  <= 1'b0;
         gnt1_reg  <= 1'b0;
         shift_reg <= '0;
         pos_reg   <= '0;
         mask_reg  <= '0;
         count_reg <= 4'd0;
         det_reg   <= S0;
         id_reg    <= 1'b0;
         last0_reg <= 1'b0;
      end else begin
         gnt0_reg <= grant && !win1;
         gnt1_reg <= grant && win1;
         if (grant) begin
            shift_reg <= win1 ? data1 : data0;
            pos_reg   <= {1'b1, {(DW-1){1'b0}}};
            mask_reg  <= '0;
            count_reg <= 4'd0;
            det_reg   <= S0;
            id_reg    <= win1;
            last0_reg <= !win1;
         end else if (state_reg == SHIFT) begin
            shift_reg <= shift_reg << 1;
            pos_reg   <= pos_reg >> 1;
            mask_reg  <= mask_next;
            count_reg <= count_next;
            det_reg   <= det_next;
         end
      end
   end

   assign gnt0         = gnt0_reg;
   assign gnt1         = gnt1_reg;
   assign result_id    = id_reg;
   assign result_count = count_reg;
   assign match_mask   = mask_reg;

endmodule

// File: tb/tb_pattern_scan_arb.sv
// Bench for pattern_scan_arb: a job-level model is checked every cycle,
// and a queue of hand-computed results is checked at each result pulse.
module tb_pattern_scan_arb;

   localparam int DW = 8;

   logic          Clk = 1'b0;
   logic          Clr;
   logic          req0, req1;
   logic [DW-1:0] data0, data1;
   logic          gnt0, gnt1, busy, result_valid, result_id;
   logic [3:0]    result_count;
   logic [DW-1:0] match_mask;

   pattern_scan_arb #(.DW(DW)) dut (
      .Clk          (Clk),
      .Clr          (Clr),
      .req0         (req0),
      .req1         (req1),
      .data0        (data0),
      .data1        (data1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .busy         (busy),
      .result_valid (result_valid),
      .result_id    (result_id),
      .result_count (result_count),
      .match_mask   (match_mask)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          id;
      int            cnt;
      logic [DW-1:0] mask;
   } res_t;
   res_t exp_q[$];

   int rv_count    = 0;
   int cyc         = 0;
   int last_rv_cyc = -1;
   bit spacing_en  = 0;
   bit hold1       = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // "101" occurrences that end inside the first n serial bits (MSB first).
   function automatic void scan(input logic [DW-1:0] d, input int n,
                                output int cnt, output logic [DW-1:0] mask);
      cnt  = 0;
      mask = '0;
      for (int k = 2; k < n; k++) begin
         if (d[DW-1-k] && !d[DW-k] && d[DW+1-k]) begin
            mask[DW-1-k] = 1'b1;
            if (cnt < 15) cnt++;
         end
      end
   endfunction

   // Job-level model: phase = edges since the grant, -1 when idle.
   int            phase  = -1;
   bit            mlast0 = 0;
   bit            mid    = 0;
   bit            mready = 0;
   logic [DW-1:0] mdata  = '0;
   logic          s_clr, s_r0, s_r1;
   logic [DW-1:0] s_d0, s_d1;
   int            e_cnt;
   logic [DW-1:0] e_mask;

   always @(posedge Clk) begin
      s_clr = Clr;
      s_r0  = req0;
      s_r1  = req1;
      s_d0  = data0;
      s_d1  = data1;
      cyc++;
      #1;
      if (s_clr) begin
         phase  = -1;
         mlast0 = 0;
         mid    = 0;
         mdata  = '0;
         mready = 1;
      end else if (mready) begin
         if (phase < 0) begin
            if (s_r0 || s_r1) begin
               mid    = s_r1 && (!s_r0 || mlast0);
               mdata  = mid ? s_d1 : s_d0;
               mlast0 = !mid;
               phase  = 0;
            end
         end else begin
            phase++;
            if (phase > DW) phase = -1;
         end
      end
      if (mready) begin
         scan(mdata, (phase < 0) ? DW : phase, e_cnt, e_mask);
         chk("gnt0", gnt0, (phase == 0) && !mid);
         chk("gnt1", gnt1, (phase == 0) && mid);
         chk("busy", busy, phase >= 0);
         chk("result_valid", result_valid, phase == DW);
         chk("result_id", result_id, mid);
         chk("result_count", result_count, e_cnt);
         chk("match_mask", match_mask, e_mask);
      end
      if (result_valid === 1'b1) begin
         rv_count++;
         $display("result id=%0d count=%0d mask=%02h cycle=%0d",
                  result_id, result_count, match_mask, cyc);
         if (spacing_en && last_rv_cyc >= 0)
            chk("rv_spacing", cyc - last_rv_cyc, 10);
         last_rv_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            res_t r;
            r = exp_q.pop_front();
            chk("dir_id", result_id, r.id);
            chk("dir_count", result_count, r.cnt);
            chk("dir_mask", match_mask, r.mask);
         end
      end
   end

   task automatic tick();
      @(negedge Clk);
      if (gnt0) req0 = 1'b0;
      if (gnt1 && !hold1) req1 = 1'b0;
   endtask

   task automatic push(input logic id, input int cnt, input logic [DW-1:0] mask);
      res_t r;
      r.id   = id;
      r.cnt  = cnt;
      r.mask = mask;
      exp_q.push_back(r);
   endtask

   task automatic wait_results(input int n, input string tag);
      int target;
      int budget;
      target = rv_count + n;
      budget = 40 * n;
      while (rv_count < target && budget > 0) begin
         tick();
         budget--;
      end
      chk({tag, "_done"}, rv_count >= target, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt0"}, gnt0, 0);
      chk({tag, "_gnt1"}, gnt1, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rv"}, result_valid, 0);
      chk({tag, "_id"}, result_id, 0);
      chk({tag, "_count"}, result_count, 0);
      chk({tag, "_mask"}, match_mask, 0);
   endtask

   initial begin
      int            c;
      int            budget;
      logic [DW-1:0] m;

      // Pin the model against hand-computed values.
      scan(8'hAA, DW, c, m); chk("model_AA_cnt", c, 3); chk("model_AA_mask", m, 8'h2A);
      scan(8'hA5, DW, c, m); chk("model_A5_cnt", c, 2); chk("model_A5_mask", m, 8'h21);
      scan(8'h05, DW, c, m); chk("model_05_cnt", c, 1); chk("model_05_mask", m, 8'h01);
      scan(8'h00, DW, c, m); chk("model_00_cnt", c, 0); chk("model_00_mask", m, 8'h00);
      scan(8'hFF, DW, c, m); chk("model_FF_cnt", c, 0); chk("model_FF_mask", m, 8'h00);

      Clr   = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      data0 = '0;
      data1 = '0;
      repeat (2) tick();
      chk_zero("reset");
      Clr = 1'b0;

      // Single request, data 0xAA.
      data0 = 8'hAA;
      req0  = 1'b1;
      push(0, 3, 8'h2A);
      wait_results(1, "single");
      repeat (2) tick();

      // Tie at the first edge after reset: req0 first, then req1.
      Clr = 1'b1;
      repeat (2) tick();
      data0 = 8'hA5;
      data1 = 8'h05;
      req0  = 1'b1;
      req1  = 1'b1;
      push(0, 2, 8'h21);
      push(1, 1, 8'h01);
      Clr = 1'b0;
      wait_results(2, "tie1");
      repeat (2) tick();

      // Later tie: requester 1 was served last, so req0 wins again.
      data0 = 8'h00;
      data1 = 8'hFF;
      req0  = 1'b1;
      req1  = 1'b1;
      push(0, 0, 8'h00);
      push(1, 0, 8'h00);
      wait_results(2, "tie2");
      repeat (2) tick();

      // Abort mid-job with Clr at edge E+4; the aborted job never reports.
      data0 = 8'hAA;
      req0  = 1'b1;
      budget = 20;
      while (!gnt0 && budget > 0) begin
         tick();
         budget--;
      end
      chk("abort_gnt0_seen", gnt0, 1);
      data1 = 8'hA5;
      req1  = 1'b1;
      repeat (3) tick();
      Clr = 1'b1;
      #1;
      chk_zero("abort");
      tick();
      Clr   = 1'b0;
      data0 = 8'hFF;
      req0  = 1'b1;
      push(0, 0, 8'h00);
      push(1, 2, 8'h21);
      wait_results(2, "after_abort");
      repeat (2) tick();

      // req1 held continuously: back-to-back jobs every 10 cycles.
      hold1       = 1;
      data1       = 8'hAA;
      req1        = 1'b1;
      last_rv_cyc = -1;
      spacing_en  = 1;
      push(1, 3, 8'h2A);
      push(1, 3, 8'h2A);
      push(1, 3, 8'h2A);
      wait_results(3, "continuous");
      hold1 = 0;
      req1  = 1'b0;
      repeat (4) tick();
      spacing_en = 0;

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_scan_arb.md
PATTERN_SCAN_ARB -- requirements
Module: pattern_scan_arb

Interface
REQ-001 Parameter DW, default 8, SHALL set the bit width of each request word; the verification scenarios use DW=8.
REQ-002 Clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-003 Clr  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 req0, req1  input  1 each  SHALL be the requester 0 and requester 1 scan requests; each SHALL be held high until the matching grant.
REQ-005 data0, data1  input  DW each  SHALL be the words to scan; each SHALL be sampled on the granting edge.
REQ-006 gnt0, gnt1  output  1 each  SHALL each be a one-cycle, registered accept pulse.
REQ-007 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-008 result_valid  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009 result_id  output  1  SHALL identify the requester that owns the result.
REQ-010 result_count  output  4  SHALL give the number of "101" detections in the word.
REQ-011 match_mask  output  DW  SHALL mark the data bit positions at which a detection completed.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and REPORT.
REQ-013 In IDLE at a rising edge E with any req high, the block SHALL perform round-robin arbitration:
  - with one request high, that requester wins;
  - with both high, the requester not served last wins;
  - the last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-014 On edge E the block SHALL:
  - latch the winner's data into a shift register;
  - clear the bit counter, result_count and match_mask;
  - set the detector to S0;
  - enter SHIFT.
  The winner's gnt SHALL be high only for the cycle after E.
REQ-015 Requesters SHALL drop req during their gnt cycle; a req still high at a later IDLE edge SHALL count as a new request.
REQ-016 SHIFT SHALL consume one serial bit per edge at edges E+1..E+DW, MSB first. Serial bit k (k=0..DW-1) SHALL be data[DW-1-k].
REQ-017 The internal detector SHALL use overlapping "101" transitions, with X being the serial bit:
  - S0: X=1 -> S1, else S0;
  - S1: X=1 -> S1, else S2;
  - S2: X=1 -> S3, else S0;
  - S3: X=1 -> S1, else S2.
REQ-018 A detection SHALL occur when the detector is in S2 and the serial bit is 1. On a detection at serial bit k, match_mask[DW-1-k] SHALL be set and result_count SHALL increment.
REQ-019 result_count SHALL saturate at 15 and SHALL NOT wrap.
REQ-020 The detector state SHALL NOT carry across words; it SHALL restart at S0 on every grant.
REQ-021 After the bit consumed at edge E+DW, the FSM SHALL enter REPORT.
  - result_valid SHALL be high for exactly that one cycle.
  - result_id, result_count and match_mask SHALL be stable during that cycle.
REQ-022 REPORT SHALL always go to IDLE on the next edge, which is E+DW+1.
REQ-023 The earliest next grant SHALL be at edge E+DW+2.
REQ-024 result_count, match_mask and result_id SHALL hold their values after REPORT until the next grant edge.
REQ-025 Requests arriving while not in IDLE SHALL be ignored until IDLE; no request SHALL be lost if it is held.
REQ-026 The detector SHALL NOT enter any state outside S0-S3. An illegal state SHALL recover to S0 on the next edge, as SHALL an illegal FSM state to IDLE.

Reset
REQ-027 While Clr is high, independent of Clk, the block SHALL:
  - set the FSM to IDLE and the detector to S0;
  - set the round-robin pointer to 1;
  - drive gnt0, gnt1, busy, result_valid, result_id, result_count and match_mask to 0.
REQ-028 If Clr asserts mid-SHIFT or mid-REPORT, the job SHALL be aborted, with no result_valid pulse. After Clr deasserts, the first edge with a request SHALL start a fresh arbitration.
REQ-029 The power-up state without Clr SHALL be the same as the reset state.

Verification
REQ-030 Scenario: req0 with data0=8'hAA granted at edge E -> gnt0=1 in the cycle after E; busy=1; result_valid in the cycle after E+8 with result_id=0, result_count=3, match_mask=8'h2A.
REQ-031 Scenario: req0 and req1 both high at the first edge after reset -> gnt0 first; req1 is granted at edge E+10 with result_id=1; a later tie is granted to req0.
REQ-032 Scenario: data=8'hA5 -> result_count=2, match_mask=8'h21. Data=8'h05 -> result_count=1, match_mask=8'h01.
REQ-033 Scenario: data=8'h00, then data=8'hFF -> result_count=0 and match_mask=8'h00 for both words.
REQ-034 Scenario: Clr pulsed at edge E+4 of a job -> all outputs 0 immediately; no result_valid pulse; a held req1 and a new req0 afterwards -> gnt0 is issued first.
REQ-035 Scenario: req1 held high continuously with req0 low -> back-to-back grants every 10 cycles; result_valid pulses every 10 cycles, never asserted two cycles in a row.
